capture_sequencer: RTL and testbench
====================================

# capture_sequencer

Sequences one sample-capture run around the ADC trigger blocks. It counts a programmed number of pre-trigger samples, then arms the trigger blocks and waits for a masked trigger from any of them. It then counts a programmed number of post-trigger samples and reports completion. It sits between the ADC sample strobe, the capture buffer write port and the trigger units, and is configured over the same 8-bit wishbone register bus as the trigger units.

## Interface
- NUM_TRIG, 4, number of trigger inputs (1..8)
- CNT_W, 16, width of sample counters and count registers (fixed 16 for the byte register map)

- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- sample_valid  in  1  one-cycle strobe per new ADC sample
- trig_in  in  NUM_TRIG  trigger pulses (sq_trigger of each trigger unit)
- sq_active  out  1  registered; high only in ARMED
- cap_we  out  1  combinational capture-buffer write enable
- done  out  1  registered; high in DONE
- wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  wishbone strobes
- wb_adr_i  in  16  register address (bits [3:0] decoded)
- wb_dat_i  in  8  write data
- wb_dat_o  out  8  combinational read data
- wb_ack_o  out  1  tied to 1

## Operation
- States: IDLE, PRE, ARMED, POST, DONE.
- Register map (write = cyc&stb&we):
  - 0 control/status. Write bit0 = start, bit1 = abort. Read {state[2:0], done, busy} in bits [4:0].
  - 1 trig_mask.
  - 2/3 pretrig lo/hi.
  - 4/5 posttrig lo/hi.
  - 6/7 trig_pos lo/hi (read-only).
  - 8 trig_src (read-only).
  - Other addresses read 0.
- busy = state in {PRE, ARMED, POST}. Writes to 1–5 are ignored while busy.
- Start (accepted in IDLE or DONE):
  - Clears sample count, trig_pos and trig_src.
  - Next state is ARMED if pretrig==0, else PRE.
- Start while busy is ignored.
- Abort moves from any state to IDLE next cycle. Abort wins over a simultaneous start.
- cap_we = sample_valid && busy.
- sample count: 16 bits, +1 per cap_we, wraps modulo 2^16.
- PRE: pre counter +1 per sample_valid. The sample making it equal pretrig moves the block to ARMED.
- ARMED: a qualified trigger is any bit of (trig_in & trig_mask). On that cycle:
  - trig_src <= the qualified bits.
  - trig_pos <= the sample count before this cycle's increment.
  - Next state is DONE if posttrig==0, else POST.
  - The trigger-cycle sample, if valid, is written and is not a post sample.
- trig_mask==0 in ARMED: the block waits indefinitely until abort.
- POST: post counter +1 per sample_valid. The sample making it equal posttrig is written, and the block moves to DONE.
- DONE: holds until start or abort. cap_we stays 0.

## Timing
- Reset values: state IDLE; sq_active, done, all counters, pretrig, posttrig, trig_mask, trig_pos, trig_src = 0. cap_we is 0 because busy is 0.
- All state changes are registered, one cycle after the causing event. sq_active and done follow state in the same registered cycle.
- A trigger asserted in the same cycle as PRE→ARMED is not seen. trig_in is qualified only while state==ARMED.
- cap_we has zero latency from sample_valid.
- Wishbone: single-cycle, always acked. Reads reflect registers as of the current cycle.

## Structure
- Shared package holds:
  - state encoding (IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4);
  - register address constants;
  - control bit positions.
- One natural sub-module: `sample_counter` (CNT_W counter with clear, enable and terminal-match output). Instantiate it for pre, post and total counts.

## Test plan
- Basic run: pretrig=3, posttrig=2, mask=0x1, start, trigger on bit0 after 5 samples. Required: ARMED after sample 3, trig_pos=5, trig_src=0x1, exactly 2 post samples, done=1, total cap_we pulses = 5+1 (if trigger-cycle sample valid)+2.
- Zero counts: pretrig=0, posttrig=0. Start gives ARMED next cycle (sq_active=1). The trigger gives DONE next cycle with no cap_we afterwards.
- Masking: mask=0x4. Pulses on trig_in bits 0 and 1 are ignored. A pulse on bit2 gives trig_src=0x4. Simultaneous bits 2 and 3 with mask=0xC give trig_src=0xC.
- Abort and lock: abort in POST gives IDLE next cycle, busy=0. Start+abort in the same cycle gives IDLE. A pretrig write while ARMED leaves the register unchanged.
- Reset mid-run: deassert rst_n in ARMED. Outputs go 0 immediately and all registers read 0.
- Wrap: pretrig=0xFFFF, then trigger after 0x10001 samples total gives trig_pos=0x0001.

Source files
------------

// File: rtl/capture_sequencer_pkg.sv
// Shared definitions for the capture sequencer: state encoding,
// register addresses and control-register bit positions.
package capture_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Register map, decoded from wb_adr_i[3:0]
  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_MASK    = 4'h1;
  localparam logic [3:0] ADDR_PRE_LO  = 4'h2;
  localparam logic [3:0] ADDR_PRE_HI  = 4'h3;
  localparam logic [3:0] ADDR_POST_LO = 4'h4;
  localparam logic [3:0] ADDR_POST_HI = 4'h5;
  localparam logic [3:0] ADDR_POS_LO  = 4'h6;
  localparam logic [3:0] ADDR_POS_HI  = 4'h7;
  localparam logic [3:0] ADDR_SRC     = 4'h8;

  // Control register write bits
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  // A run is in progress while counting pre samples, armed, or counting post samples
  function automatic logic is_busy(input state_e s);
    return (s == ST_PRE) || (s == ST_ARMED) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// 8-bit wishbone register bus shared with the trigger units.
// Signal names are from the register-slave point of view.
interface capture_sequencer_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [15:0] wb_adr_i;
  logic [7:0]  wb_dat_i;
  logic [7:0]  wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/capture_sequencer_sample_counter.sv
// Wrapping sample counter with synchronous clear, count enable and a
// terminal-match flag that fires on the increment reaching target_i.
module capture_sequencer_sample_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] target_i,
  output logic [CNT_W-1:0] count_o,
  output logic             hit_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign count_o = count_q;
  // Match is on the value after this cycle's increment
  assign hit_o   = en_i && (count_d == target_i);

  // Counter register: clear wins over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Capture sequencer: pre-trigger count, armed wait for a masked trigger,
// post-trigger count, then done. Configured over the 8-bit wishbone bus.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int NUM_TRIG = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [NUM_TRIG-1:0] trig_in,
  output logic                sq_active,
  output logic                cap_we,
  output logic                done,
  capture_sequencer_if.slave  bus
);

  state_e              state_q, state_d;
  logic                sq_active_q, done_q;
  logic [NUM_TRIG-1:0] trig_mask_q, trig_src_q;
  logic [CNT_W-1:0]    pretrig_q, posttrig_q, trig_pos_q;

  logic [3:0]          adr;
  logic                wr_en, ctrl_wr, start_req, abort_req, start_ok, busy;
  logic [NUM_TRIG-1:0] trig_qual;
  logic                pre_en, post_en, pre_hit, post_hit;
  logic [CNT_W-1:0]    total_cnt;
  logic [CNT_W-1:0]    pre_cnt_unused, post_cnt_unused;
  logic                total_hit_unused;
  logic [11:0]         adr_hi_unused;
  logic [7:0]          rdata;

  assign adr           = bus.wb_adr_i[3:0];
  assign adr_hi_unused = bus.wb_adr_i[15:4];
  assign wr_en         = bus.wb_cyc_i && bus.wb_stb_i && bus.wb_we_i;
  assign ctrl_wr       = wr_en && (adr == ADDR_CTRL);
  assign abort_req     = ctrl_wr && bus.wb_dat_i[CTRL_ABORT_BIT];
  assign start_req     = ctrl_wr && bus.wb_dat_i[CTRL_START_BIT];
  assign busy          = is_busy(state_q);
  // Abort beats start; start is only honoured from IDLE or DONE
  assign start_ok      = start_req && !abort_req && !busy;

  assign cap_we    = sample_valid && busy;
  assign trig_qual = (state_q == ST_ARMED) ? (trig_in & trig_mask_q) : '0;
  assign pre_en    = (state_q == ST_PRE) && sample_valid;
  assign post_en   = (state_q == ST_POST) && sample_valid;

  assign sq_active    = sq_active_q;
  assign done         = done_q;
  assign bus.wb_ack_o = 1'b1;
  assign bus.wb_dat_o = rdata;

  capture_sequencer_sample_counter #(.CNT_W(CNT_W)) u_pre_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(start_ok), .en_i(pre_en),
    .target_i(pretrig_q), .count_o(pre_cnt_unused), .hit_o(pre_hit)
  );

  capture_sequencer_sample_counter #(.CNT_W(CNT_W)) u_post_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(start_ok), .en_i(post_en),
    .target_i(posttrig_q), .count_o(post_cnt_unused), .hit_o(post_hit)
  );

  // Total count of written samples; its match output is not needed
  capture_sequencer_sample_counter #(.CNT_W(CNT_W)) u_total_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(start_ok), .en_i(cap_we),
    .target_i('0), .count_o(total_cnt), .hit_o(total_hit_unused)
  );

  // Next-state decode
  always_comb begin
    state_d = state_q;
    if (abort_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start_req) state_d = (pretrig_q == '0) ? ST_ARMED : ST_PRE;
        ST_PRE:           if (pre_hit) state_d = ST_ARMED;
        ST_ARMED:         if (|trig_qual) state_d = (posttrig_q == '0) ? ST_DONE : ST_POST;
        ST_POST:          if (post_hit) state_d = ST_DONE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  // State, registered status outputs and trigger capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sq_active_q <= 1'b0;
      done_q      <= 1'b0;
      trig_pos_q  <= '0;
      trig_src_q  <= '0;
    end else begin
      state_q     <= state_d;
      sq_active_q <= (state_d == ST_ARMED);
      done_q      <= (state_d == ST_DONE);
      if (start_ok) begin
        trig_pos_q <= '0;
        trig_src_q <= '0;
      end else if (!abort_req && (|trig_qual)) begin
        trig_src_q <= trig_qual;
        trig_pos_q <= total_cnt;  // count before this cycle's increment
      end
    end
  end

  // Configuration registers, locked while a run is in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_mask_q <= '0;
      pretrig_q   <= '0;
      posttrig_q  <= '0;
    end else if (wr_en && !busy) begin
      case (adr)
        ADDR_MASK:    trig_mask_q      <= bus.wb_dat_i[NUM_TRIG-1:0];
        ADDR_PRE_LO:  pretrig_q[7:0]   <= bus.wb_dat_i;
        ADDR_PRE_HI:  pretrig_q[15:8]  <= bus.wb_dat_i;
        ADDR_POST_LO: posttrig_q[7:0]  <= bus.wb_dat_i;
        ADDR_POST_HI: posttrig_q[15:8] <= bus.wb_dat_i;
        default: ;
      endcase
    end
  end

  // Register read mux
  always_comb begin
    rdata = '0;
    case (adr)
      ADDR_CTRL:    rdata = {3'b000, state_q, done_q, busy};
      ADDR_MASK:    rdata[NUM_TRIG-1:0] = trig_mask_q;
      ADDR_PRE_LO:  rdata = pretrig_q[7:0];
      ADDR_PRE_HI:  rdata = pretrig_q[15:8];
      ADDR_POST_LO: rdata = posttrig_q[7:0];
      ADDR_POST_HI: rdata = posttrig_q[15:8];
      ADDR_POS_LO:  rdata = trig_pos_q[7:0];
      ADDR_POS_HI:  rdata = trig_pos_q[15:8];
      ADDR_SRC:     rdata[NUM_TRIG-1:0] = trig_src_q;
      default:      rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: table-driven basic run and register
// readback, plus hand-written sequences for zero counts, masking, abort,
// reset mid-run and sample-count wrap.
module tb_capture_sequencer;
  import capture_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_valid;
  logic [3:0] trig_in;
  logic       sq_active, cap_we, done;

  capture_sequencer_if bus();

  capture_sequencer #(.NUM_TRIG(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .trig_in(trig_in),
    .sq_active(sq_active), .cap_we(cap_we), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cap_cnt  = 0;

  typedef struct {
    logic       sv;
    logic [3:0] trig;
    logic       exp_act;
    logic       exp_done;
    logic       exp_we;
  } vec_t;

  typedef struct {
    logic [3:0] adr;
    logic [7:0] exp;
  } rd_t;

  vec_t basic_vecs [12];
  rd_t  basic_rds  [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, got);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; sample combinational outputs 1ns later
  task automatic drive(input logic sv, input logic [3:0] trig, input logic wr,
                       input logic [3:0] adr, input logic [7:0] dat);
    @(negedge clk);
    sample_valid = sv;
    trig_in      = trig;
    bus.wb_cyc_i = wr;
    bus.wb_stb_i = wr;
    bus.wb_we_i  = wr;
    bus.wb_adr_i = {12'h000, adr};
    bus.wb_dat_i = dat;
    #1;
    if (cap_we) cap_cnt++;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic wr(input logic [3:0] adr, input logic [7:0] dat);
    drive(1'b0, 4'h0, 1'b1, adr, dat);
  endtask

  task automatic rd_check(input string name, input logic [3:0] adr, input logic [7:0] exp);
    @(negedge clk);
    sample_valid = 1'b0;
    trig_in      = 4'h0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = {12'h000, adr};
    bus.wb_dat_i = 8'h00;
    #1;
    check(name, {24'h0, bus.wb_dat_o}, {24'h0, exp});
  endtask

  initial begin
    // Basic run: pretrig=3, posttrig=2, mask=1; {sv, trig, exp_act, exp_done, exp_we}
    basic_vecs[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1};  // PRE sample 1
    basic_vecs[1]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1};  // PRE sample 2
    basic_vecs[2]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b1};  // PRE sample 3, trigger not seen
    basic_vecs[3]  = '{1'b1, 4'h0, 1'b1, 1'b0, 1'b1};  // ARMED sample 4
    basic_vecs[4]  = '{1'b1, 4'h0, 1'b1, 1'b0, 1'b1};  // ARMED sample 5
    basic_vecs[5]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0};  // ARMED no sample
    basic_vecs[6]  = '{1'b1, 4'h1, 1'b1, 1'b0, 1'b1};  // trigger, sample written
    basic_vecs[7]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0};  // POST no sample
    basic_vecs[8]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1};  // post 1
    basic_vecs[9]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b1};  // post 2 -> DONE
    basic_vecs[10] = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0};  // DONE, no write
    basic_vecs[11] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0};
    basic_rds[0] = '{ADDR_POS_LO,  8'h05};
    basic_rds[1] = '{ADDR_POS_HI,  8'h00};
    basic_rds[2] = '{ADDR_SRC,     8'h01};
    basic_rds[3] = '{ADDR_CTRL,    8'h12};  // state DONE, done=1, busy=0
    basic_rds[4] = '{ADDR_PRE_LO,  8'h03};
    basic_rds[5] = '{ADDR_MASK,    8'h01};
    basic_rds[6] = '{ADDR_POST_LO, 8'h02};
    basic_rds[7] = '{4'h9,         8'h00};
    basic_rds[8] = '{4'hF,         8'h00};

    rst_n = 1'b0;
    sample_valid = 1'b0;
    trig_in = 4'h0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 16'h0000;
    bus.wb_dat_i = 8'h00;

    // Reset state
    #1;
    check("rst_sq_active", sq_active, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cap_we", cap_we, 1'b0);
    check("wb_ack", bus.wb_ack_o, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_check("rst_status", ADDR_CTRL, 8'h00);
    rd_check("rst_pre_lo", ADDR_PRE_LO, 8'h00);

    // Basic run
    wr(ADDR_MASK, 8'h01);
    wr(ADDR_PRE_LO, 8'h03);
    wr(ADDR_PRE_HI, 8'h00);
    wr(ADDR_POST_LO, 8'h02);
    wr(ADDR_POST_HI, 8'h00);
    cap_cnt = 0;
    wr(ADDR_CTRL, 8'h01);
    for (int i = 0; i < 12; i++) begin
      drive(basic_vecs[i].sv, basic_vecs[i].trig, 1'b0, 4'h0, 8'h00);
      check($sformatf("basic[%0d].sq_active", i), sq_active, basic_vecs[i].exp_act);
      check($sformatf("basic[%0d].done", i), done, basic_vecs[i].exp_done);
      check($sformatf("basic[%0d].cap_we", i), cap_we, basic_vecs[i].exp_we);
    end
    check("basic_cap_we_total", cap_cnt, 8);
    for (int i = 0; i < 9; i++) begin
      rd_check($sformatf("basic_rd[%0d]", i), basic_rds[i].adr, basic_rds[i].exp);
    end

    // Zero counts
    wr(ADDR_PRE_LO, 8'h00);
    wr(ADDR_POST_LO, 8'h00);
    wr(ADDR_CTRL, 8'h01);
    idle();
    check("zero_armed", sq_active, 1'b1);
    drive(1'b1, 4'h1, 1'b0, 4'h0, 8'h00);
    check("zero_trig_cycle_we", cap_we, 1'b1);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 8'h00);
    check("zero_done", done, 1'b1);
    check("zero_not_active", sq_active, 1'b0);
    check("zero_no_we_after", cap_we, 1'b0);

    // Masking
    wr(ADDR_MASK, 8'h04);
    wr(ADDR_CTRL, 8'h01);
    drive(1'b0, 4'h1, 1'b0, 4'h0, 8'h00);
    drive(1'b0, 4'h2, 1'b0, 4'h0, 8'h00);
    idle();
    check("mask_ignored", sq_active, 1'b1);
    drive(1'b0, 4'h4, 1'b0, 4'h0, 8'h00);
    idle();
    check("mask_bit2_done", done, 1'b1);
    rd_check("mask_src_4", ADDR_SRC, 8'h04);
    wr(ADDR_MASK, 8'h0C);
    wr(ADDR_CTRL, 8'h01);
    drive(1'b0, 4'hC, 1'b0, 4'h0, 8'h00);
    idle();
    check("mask_c_done", done, 1'b1);
    rd_check("mask_src_c", ADDR_SRC, 8'h0C);

    // Mask zero waits until abort
    wr(ADDR_MASK, 8'h00);
    wr(ADDR_CTRL, 8'h01);
    repeat (3) drive(1'b0, 4'hF, 1'b0, 4'h0, 8'h00);
    idle();
    check("mask0_waits", sq_active, 1'b1);
    wr(ADDR_CTRL, 8'h02);
    idle();
    check("mask0_abort", sq_active, 1'b0);

    // Abort and configuration lock
    wr(ADDR_MASK, 8'h01);
    wr(ADDR_POST_LO, 8'h02);
    wr(ADDR_CTRL, 8'h01);
    wr(ADDR_PRE_LO, 8'h07);
    rd_check("lock_pre_lo", ADDR_PRE_LO, 8'h00);
    drive(1'b0, 4'h1, 1'b0, 4'h0, 8'h00);
    rd_check("post_status", ADDR_CTRL, 8'h0D);
    wr(ADDR_CTRL, 8'h02);
    rd_check("abort_status", ADDR_CTRL, 8'h00);
    wr(ADDR_CTRL, 8'h03);
    rd_check("start_abort_status", ADDR_CTRL, 8'h00);
    check("start_abort_active", sq_active, 1'b0);

    // Reset mid-run
    wr(ADDR_CTRL, 8'h01);
    idle();
    check("pre_reset_armed", sq_active, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    sample_valid = 1'b1;
    #1;
    check("reset_sq_active", sq_active, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_cap_we", cap_we, 1'b0);
    rd_check("reset_status", ADDR_CTRL, 8'h00);
    rd_check("reset_mask", ADDR_MASK, 8'h00);
    rd_check("reset_post_lo", ADDR_POST_LO, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Sample-count wrap: 0xFFFF pre samples, 2 armed samples, then trigger
    wr(ADDR_MASK, 8'h01);
    wr(ADDR_PRE_LO, 8'hFF);
    wr(ADDR_PRE_HI, 8'hFF);
    wr(ADDR_CTRL, 8'h01);
    for (int i = 0; i < 65534; i++) drive(1'b1, 4'h0, 1'b0, 4'h0, 8'h00);
    idle();
    check("wrap_pre_not_armed", sq_active, 1'b0);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 8'h00);
    idle();
    check("wrap_armed", sq_active, 1'b1);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 8'h00);
    drive(1'b0, 4'h1, 1'b0, 4'h0, 8'h00);
    idle();
    check("wrap_done", done, 1'b1);
    rd_check("wrap_pos_lo", ADDR_POS_LO, 8'h01);
    rd_check("wrap_pos_hi", ADDR_POS_HI, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
